// File: rtl/hid_bus_arbiter_if.sv
// Requester-side and HID-side signal bundle for hid_bus_arbiter.
// master = the arbiter (drives grants, responses and the HID command); slave = requesters plus HID slave.
interface hid_bus_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64
);
  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        lock_i;
  logic [NREQ*8-1:0]      req_we_i;
  logic [NREQ*ADDR_W-1:0] req_addr_i;
  logic [NREQ*DATA_W-1:0] req_wdata_i;
  logic [NREQ-1:0]        gnt_o;
  logic [NREQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]      rdata_o;
  logic                   hid_en;
  logic [7:0]             hid_we;
  logic [ADDR_W-1:0]      hid_addr;
  logic [DATA_W-1:0]      hid_wrdata;
  logic [DATA_W-1:0]      hid_rddata;

  modport master (
    input  req_i, lock_i, req_we_i, req_addr_i, req_wdata_i, hid_rddata,
    output gnt_o, rvalid_o, rdata_o, hid_en, hid_we, hid_addr, hid_wrdata
  );

  modport slave (
    output req_i, lock_i, req_we_i, req_addr_i, req_wdata_i, hid_rddata,
    input  gnt_o, rvalid_o, rdata_o, hid_en, hid_we, hid_addr, hid_wrdata
  );
endinterface

// File: rtl/hid_bus_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing the HID slave port between NREQ requesters.
// Grant is combinational at N, command registered at N+1, response routed by ID tag at N+2; no backpressure.
module hid_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 64,
  parameter int MAX_HOLD = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  hid_bus_arbiter_if.master bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST     = IDW'(NREQ - 1);
  localparam logic [3:0]     HOLD_MAX = 4'(MAX_HOLD);

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    owner;
  logic              owner_vld;
  logic [3:0]        hold_cnt;
  logic              lock_cont;
  logic              any_req;
  logic              gnt_vld;
  logic [IDW-1:0]    win;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              hid_en_q;
  logic [7:0]        hid_we_q;
  logic [ADDR_W-1:0] hid_addr_q;
  logic [DATA_W-1:0] hid_wrdata_q;
  logic [IDW-1:0]    iss_tag;
  logic              rsp_vld;
  logic [IDW-1:0]    rsp_tag;
  logic [NREQ-1:0]   rvalid;

  // Scan runs from the far end back toward rr_ptr so the nearest requester overwrites.
  always_comb begin
    lock_cont = owner_vld && bus.req_i[owner] && (hold_cnt < HOLD_MAX);
    win       = rr_ptr;
    any_req   = 1'b0;
    if (lock_cont) begin
      win     = owner;
      any_req = 1'b1;
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (bus.req_i[(int'(rr_ptr) + i) % NREQ]) begin
          win     = IDW'((int'(rr_ptr) + i) % NREQ);
          any_req = 1'b1;
        end
      end
    end
    gnt_vld = any_req && rst_ni;
    gnt     = '0;
    if (gnt_vld) gnt[win] = 1'b1;
  end

  always_comb begin
    sel_we    = bus.req_we_i[8*int'(win) +: 8];
    sel_addr  = bus.req_addr_i[ADDR_W*int'(win) +: ADDR_W];
    sel_wdata = bus.req_wdata_i[DATA_W*int'(win) +: DATA_W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr       <= '0;
      owner        <= '0;
      owner_vld    <= 1'b0;
      hold_cnt     <= 4'd0;
      hid_en_q     <= 1'b0;
      hid_we_q     <= 8'd0;
      hid_addr_q   <= '0;
      hid_wrdata_q <= '0;
      iss_tag      <= '0;
      rsp_vld      <= 1'b0;
      rsp_tag      <= '0;
    end else begin
      // An expired or abandoned lock is dropped even when nobody else is granted.
      if (owner_vld && !lock_cont) begin
        owner_vld <= 1'b0;
        hold_cnt  <= 4'd0;
      end
      if (gnt_vld) begin
        if (!bus.lock_i[win]) begin
          owner_vld <= 1'b0;
          hold_cnt  <= 4'd0;
        end else if (lock_cont) begin
          hold_cnt  <= hold_cnt + 4'd1;
        end else begin
          owner_vld <= 1'b1;
          owner     <= win;
          hold_cnt  <= 4'd1;
        end
        if (!lock_cont) rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
        hid_we_q     <= sel_we;
        hid_addr_q   <= sel_addr;
        hid_wrdata_q <= sel_wdata;
        iss_tag      <= win;
      end
      hid_en_q <= gnt_vld;
      rsp_vld  <= hid_en_q;
      rsp_tag  <= iss_tag;
    end
  end

  always_comb begin
    rvalid = '0;
    if (rsp_vld) rvalid[rsp_tag] = 1'b1;
  end

  assign bus.gnt_o      = gnt;
  assign bus.rvalid_o   = rvalid;
  assign bus.rdata_o    = bus.hid_rddata;
  assign bus.hid_en     = hid_en_q;
  assign bus.hid_we     = hid_we_q;
  assign bus.hid_addr   = hid_addr_q;
  assign bus.hid_wrdata = hid_wrdata_q;
endmodule

// File: tb/tb_hid_bus_arbiter.sv
// Bench for hid_bus_arbiter: per-cycle reference model plus directed scenarios with literal expectations.
module tb_hid_bus_arbiter;
  localparam int NREQ     = 2;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 64;
  localparam int MAX_HOLD = 4;

  logic clk_i;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   win_log[$];

  hid_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  hid_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] slave_data(input logic [19:0] a);
    return (a == 20'h30000) ? 64'hDEAD_BEEF_0123_4567 : {32'hC0DE_0000, 12'h0, a};
  endfunction

  always @(posedge clk_i) bus.hid_rddata <= bus.hid_en ? slave_data(bus.hid_addr) : 64'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lock owner (-1 = none), consecutive grant count, pointer, two pipeline slots.
  int          m_ptr, m_owner, m_hold;
  logic        iss_v, rsp_v;
  int          iss_id, rsp_id;
  logic [7:0]  h_we, rsp_we;
  logic [19:0] h_addr, rsp_addr;
  logic [63:0] h_wd;

  function automatic int pick(input logic [NREQ-1:0] rq);
    if (m_owner >= 0 && rq[m_owner] && m_hold < MAX_HOLD) return m_owner;
    for (int i = 0; i < NREQ; i++)
      if (rq[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  always @(negedge clk_i) begin
    logic [NREQ-1:0] e_gnt, e_rv;
    int w;
    bit cont;
    if (!rst_ni) begin
      chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
      chk("rst_hid_en", 64'(bus.hid_en), 64'(0));
      chk("rst_hid_we", 64'(bus.hid_we), 64'(0));
      chk("rst_hid_addr", 64'(bus.hid_addr), 64'(0));
      chk("rst_hid_wrdata", bus.hid_wrdata, 64'(0));
      chk("rst_rvalid", 64'(bus.rvalid_o), 64'(0));
      m_ptr = 0; m_owner = -1; m_hold = 0;
      iss_v = 1'b0; rsp_v = 1'b0; iss_id = 0; rsp_id = 0;
      h_we = '0; h_addr = '0; h_wd = '0; rsp_we = '0; rsp_addr = '0;
    end else begin
      chk("hid_en", 64'(bus.hid_en), 64'(iss_v));
      chk("hid_we", 64'(bus.hid_we), 64'(h_we));
      chk("hid_addr", 64'(bus.hid_addr), 64'(h_addr));
      chk("hid_wrdata", bus.hid_wrdata, h_wd);
      e_rv = '0;
      if (rsp_v) e_rv[rsp_id] = 1'b1;
      chk("rvalid", 64'(bus.rvalid_o), 64'(e_rv));
      if (rsp_v && rsp_we == 8'h00) chk("rdata", bus.rdata_o, slave_data(rsp_addr));

      w = pick(bus.req_i);
      e_gnt = '0;
      if (w >= 0) e_gnt[w] = 1'b1;
      chk("gnt", 64'(bus.gnt_o), 64'(e_gnt));
      win_log.push_back(w);

      cont = (m_owner >= 0 && bus.req_i[m_owner] && m_hold < MAX_HOLD);
      if (m_owner >= 0 && !cont) begin m_owner = -1; m_hold = 0; end
      if (w >= 0) begin
        if (!bus.lock_i[w]) begin m_owner = -1; m_hold = 0; end
        else if (cont) m_hold++;
        else begin m_owner = w; m_hold = 1; end
        if (!cont) m_ptr = (w + 1) % NREQ;
      end

      rsp_v = iss_v; rsp_id = iss_id; rsp_we = h_we; rsp_addr = h_addr;
      iss_v = (w >= 0);
      if (w >= 0) begin
        iss_id = w;
        h_we   = bus.req_we_i[8*w +: 8];
        h_addr = bus.req_addr_i[ADDR_W*w +: ADDR_W];
        h_wd   = bus.req_wdata_i[DATA_W*w +: DATA_W];
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(input int k, input logic [7:0] we, input logic [19:0] a, input logic [63:0] d);
    bus.req_we_i[8*k +: 8]              = we;
    bus.req_addr_i[ADDR_W*k +: ADDR_W]  = a;
    bus.req_wdata_i[DATA_W*k +: DATA_W] = d;
  endtask

  task automatic do_reset();
    bus.req_i  = '0;
    bus.lock_i = '0;
    rst_ni = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic chk_log(input string nm, input int n, input int exp_seq[10]);
    chk({nm, "_len"}, 64'(win_log.size() >= n), 64'(1));
    for (int i = 0; i < n && i < win_log.size(); i++)
      chk(nm, 64'(win_log[i]), 64'(exp_seq[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int seq_alt[10]  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    int seq_lock[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int seq_rel[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    rst_ni          = 1'b0;
    bus.req_i       = '0;
    bus.lock_i      = '0;
    bus.req_we_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    cyc();
    cyc();
    rst_ni = 1'b1;

    // Single read by requester 0
    set_cmd(0, 8'h00, 20'h30000, 64'h0);
    bus.req_i = 2'b01;
    @(negedge clk_i);
    chk("t1_gnt", 64'(bus.gnt_o), 64'(2'b01));
    cyc();
    bus.req_i = 2'b00;
    @(negedge clk_i);
    chk("t1_hid_en", 64'(bus.hid_en), 64'(1));
    chk("t1_hid_we", 64'(bus.hid_we), 64'(8'h00));
    chk("t1_hid_addr", 64'(bus.hid_addr), 64'(20'h30000));
    cyc();
    @(negedge clk_i);
    chk("t1_rvalid", 64'(bus.rvalid_o), 64'(2'b01));
    chk("t1_rdata", bus.rdata_o, 64'hDEAD_BEEF_0123_4567);
    cyc();

    // Both requesters, no lock: strict alternation
    do_reset();
    set_cmd(0, 8'h00, 20'h00100, 64'h0);
    set_cmd(1, 8'h00, 20'h00200, 64'h0);
    bus.req_i = 2'b11;
    win_log.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (i >= 1) chk("t2_hid_en", 64'(bus.hid_en), 64'(1));
      if (i >= 2) chk("t2_rvalid", 64'(bus.rvalid_o), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      cyc();
    end
    chk_log("t2_seq", 6, seq_alt);

    // Requester 0 locked, bounded by MAX_HOLD
    do_reset();
    set_cmd(0, 8'h00, 20'h00300, 64'h0);
    set_cmd(1, 8'h00, 20'h00400, 64'h0);
    bus.req_i  = 2'b11;
    bus.lock_i = 2'b01;
    win_log.delete();
    repeat (10) cyc();
    chk_log("t3_seq", 10, seq_lock);

    // Write from requester 1 interleaved with reads from requester 0
    do_reset();
    set_cmd(0, 8'h00, 20'h00500, 64'h0);
    set_cmd(1, 8'hFF, 20'h40000, 64'h1);
    bus.req_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("t4_gnt", 64'(bus.gnt_o), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      if (i >= 1) chk("t4_hid_we", 64'(bus.hid_we), 64'((i % 2 == 0) ? 8'hFF : 8'h00));
      if (i >= 1) chk("t4_hid_addr", 64'(bus.hid_addr), 64'((i % 2 == 0) ? 20'h40000 : 20'h00500));
      if (i >= 2) chk("t4_rvalid", 64'(bus.rvalid_o), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      cyc();
    end

    // Reset right after a grant discards the in-flight command
    do_reset();
    set_cmd(0, 8'h00, 20'h00600, 64'h0);
    set_cmd(1, 8'h00, 20'h00601, 64'h0);
    bus.req_i = 2'b01;
    @(negedge clk_i);
    chk("t5_gnt_pre", 64'(bus.gnt_o), 64'(2'b01));
    cyc();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t5_hid_en_rst", 64'(bus.hid_en), 64'(0));
    chk("t5_rvalid_rst", 64'(bus.rvalid_o), 64'(0));
    chk("t5_gnt_rst", 64'(bus.gnt_o), 64'(0));
    cyc();
    @(negedge clk_i);
    chk("t5_rvalid_rst2", 64'(bus.rvalid_o), 64'(0));
    cyc();
    rst_ni    = 1'b1;
    bus.req_i = 2'b11;
    @(negedge clk_i);
    chk("t5_gnt_post", 64'(bus.gnt_o), 64'(2'b01));
    chk("t5_hid_en_post", 64'(bus.hid_en), 64'(0));
    cyc();
    @(negedge clk_i);
    chk("t5_rvalid_post", 64'(bus.rvalid_o), 64'(0));
    cyc();
    bus.req_i = 2'b00;
    @(negedge clk_i);
    chk("t5_rvalid_first", 64'(bus.rvalid_o), 64'(2'b01));
    cyc();

    // Locked owner drops req mid-burst
    do_reset();
    set_cmd(0, 8'h00, 20'h00700, 64'h0);
    set_cmd(1, 8'h00, 20'h00800, 64'h0);
    bus.req_i  = 2'b11;
    bus.lock_i = 2'b01;
    cyc();
    cyc();
    bus.req_i = 2'b10;
    @(negedge clk_i);
    chk("t6_gnt_drop", 64'(bus.gnt_o), 64'(2'b10));
    cyc();
    bus.req_i = 2'b11;
    win_log.delete();
    repeat (5) cyc();
    chk_log("t6_seq", 5, seq_rel);
    bus.req_i  = '0;
    bus.lock_i = '0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
